// File: rtl/dmem_axi_master.sv
// dmem_axi_master: LSU-side AXI4-Lite master bridge for the data-memory path.
// Turns one outstanding CPU load/store request into a single AXI read (AR/R)
// or write (AW/W/B) transaction and returns a one-cycle completion pulse.
// Optional build macro AXI_TIMEOUT_EN adds a no-progress watchdog that
// aborts a stuck transaction after TIMEOUT_CYCLES cycles with an error response.
module dmem_axi_master #(
    parameter int XLEN           = 32,
    parameter int AXI_ADDR_BITS  = 32,
    parameter int AXI_DATA_BITS  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    // LSU request side
    input  logic                       cpu_req_valid,
    output logic                       cpu_req_ready,
    input  logic                       cpu_req_we,
    input  logic [XLEN-1:0]            cpu_req_addr,
    input  logic [XLEN-1:0]            cpu_req_wdata,
    input  logic [AXI_DATA_BITS/8-1:0] cpu_req_wstrb,
    // LSU response side
    output logic                       cpu_resp_valid,
    output logic [XLEN-1:0]            cpu_resp_rdata,
    output logic                       cpu_resp_err,
    // AXI read address channel
    output logic [AXI_ADDR_BITS-1:0]   ARADDR_M,
    output logic                       ARVALID_M,
    input  logic                       ARREADY_M,
    // AXI read data channel
    input  logic [AXI_DATA_BITS-1:0]   RDATA_M,
    input  logic [1:0]                 RRESP_M,
    input  logic                       RVALID_M,
    output logic                       RREADY_M,
    // AXI write address channel
    output logic [AXI_ADDR_BITS-1:0]   AWADDR_M,
    output logic                       AWVALID_M,
    input  logic                       AWREADY_M,
    // AXI write data channel
    output logic [AXI_DATA_BITS-1:0]   WDATA_M,
    output logic [AXI_DATA_BITS/8-1:0] WSTRB_M,
    output logic                       WVALID_M,
    input  logic                       WREADY_M,
    // AXI write response channel
    input  logic [1:0]                 BRESP_M,
    input  logic                       BVALID_M,
    output logic                       BREADY_M
);

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t                     state_q,      state_d;
    logic [XLEN-1:0]            addr_q,       addr_d;
    logic [XLEN-1:0]            wdata_q,      wdata_d;
    logic [AXI_DATA_BITS/8-1:0] wstrb_q,      wstrb_d;
    logic                       aw_done_q,    aw_done_d;
    logic                       w_done_q,     w_done_d;
    logic                       resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]            resp_rdata_q, resp_rdata_d;
    logic                       resp_err_q,   resp_err_d;
    logic                       timeout;

    // All AXI VALID/READY outputs are decoded from registered state only, so
    // no VALID ever depends combinationally on a READY.
    assign cpu_req_ready = (state_q == S_IDLE);
    assign ARVALID_M     = (state_q == S_RD_ADDR);
    assign RREADY_M      = (state_q == S_RD_DATA);
    assign AWVALID_M     = (state_q == S_WR) && !aw_done_q;
    assign WVALID_M      = (state_q == S_WR) && !w_done_q;
    assign BREADY_M      = (state_q == S_WR_RESP);

    // Address, data and strobe come straight from the latched request, so they
    // cannot change while a VALID is held.
    assign ARADDR_M = addr_q;
    assign AWADDR_M = addr_q;
    assign WDATA_M  = wdata_q;
    assign WSTRB_M  = wstrb_q;

    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign cpu_resp_err   = resp_err_q;

`ifdef AXI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            progress;

    // Any handshake on any channel counts as forward progress.
    assign progress = (ARVALID_M && ARREADY_M) || (RREADY_M && RVALID_M)
                   || (AWVALID_M && AWREADY_M) || (WVALID_M && WREADY_M)
                   || (BREADY_M && BVALID_M);

    // Watchdog fires only when the limit is reached with no handshake in the
    // same cycle; a last-moment handshake always wins.
    assign timeout = (state_q != S_IDLE) && !progress
                  && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Stall counter: idle and progress hold it at zero, otherwise count up.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == S_IDLE || progress || timeout) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic timeout_param_unused;

    // Without the watchdog the bridge waits on the slave indefinitely.
    assign timeout              = 1'b0;
    assign timeout_param_unused = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state and datapath decode for the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    addr_d    = cpu_req_addr;
                    wdata_d   = cpu_req_wdata;
                    wstrb_d   = cpu_req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cpu_req_we ? S_WR : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (ARREADY_M) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (RVALID_M) begin
                    resp_rdata_d = RDATA_M;
                    resp_err_d   = (RRESP_M != AXI_RESP_OKAY);
                    resp_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_WR: begin
                // AW and W complete independently; move on once both have,
                // which also covers both finishing in the same cycle.
                aw_done_d = aw_done_q || AWREADY_M;
                w_done_d  = w_done_q  || WREADY_M;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (BVALID_M) begin
                    resp_err_d   = (BRESP_M != AXI_RESP_OKAY);
                    resp_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog abort: drop everything and report an error, keeping the
        // last load data.
        if (timeout) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_axi_master.sv
// tb_dmem_axi_master: directed bench for the dmem AXI4-Lite master bridge.
// A transaction-level model tracks the outstanding request and which AXI
// handshakes it still owes, and a negedge compare process checks every DUT
// output against it each cycle. Directed scenarios add literal expectations.
module tb_dmem_axi_master;

    localparam int TO = 8;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic [3:0]  cpu_req_wstrb;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_err;
    logic [31:0] ARADDR_M;
    logic        ARVALID_M;
    logic        ARREADY_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RVALID_M;
    logic        RREADY_M;
    logic [31:0] AWADDR_M;
    logic        AWVALID_M;
    logic        AWREADY_M;
    logic [31:0] WDATA_M;
    logic [3:0]  WSTRB_M;
    logic        WVALID_M;
    logic        WREADY_M;
    logic [1:0]  BRESP_M;
    logic        BVALID_M;
    logic        BREADY_M;

    always #5 ACLK = ~ACLK;

    dmem_axi_master #(
        .XLEN(32), .AXI_ADDR_BITS(32), .AXI_DATA_BITS(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .cpu_resp_err(cpu_resp_err),
        .ARADDR_M(ARADDR_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWADDR_M(AWADDR_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        m_live = 1'b0;
    logic        m_busy, m_we, m_ar, m_aw, m_w, m_rv, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    int          m_stall;
    int          arv_cnt = 0, awv_cnt = 0, wv_cnt = 0, rr_cnt = 0, br_cnt = 0, resp_cnt = 0;

    always @(negedge ACLK) begin
        logic n_rv, prog, e_arv, e_awv, e_wv;
        if (!m_live) begin
            if (ARESET === 1'b1) begin
                m_live = 1'b1;
                m_busy = 0; m_we = 0; m_ar = 0; m_aw = 0; m_w = 0;
                m_rv = 0; m_err = 0; m_rdata = '0; m_addr = '0; m_wdata = '0;
                m_wstrb = '0; m_stall = 0;
            end
        end else begin
            arv_cnt  += int'(ARVALID_M);
            awv_cnt  += int'(AWVALID_M);
            wv_cnt   += int'(WVALID_M);
            rr_cnt   += int'(RREADY_M);
            br_cnt   += int'(BREADY_M);
            resp_cnt += int'(cpu_resp_valid);

            e_arv = m_busy && !m_we && !m_ar;
            e_awv = m_busy && m_we && !m_aw;
            e_wv  = m_busy && m_we && !m_w;
            check("req_ready",  cpu_req_ready,  !m_busy);
            check("resp_valid", cpu_resp_valid, m_rv);
            check("resp_rdata", cpu_resp_rdata, m_rdata);
            check("resp_err",   cpu_resp_err,   m_err);
            check("arvalid",    ARVALID_M,      e_arv);
            if (e_arv) check("araddr", ARADDR_M, m_addr);
            check("rready",     RREADY_M,       m_busy && !m_we && m_ar);
            check("awvalid",    AWVALID_M,      e_awv);
            if (e_awv) check("awaddr", AWADDR_M, m_addr);
            check("wvalid",     WVALID_M,       e_wv);
            if (e_wv) begin
                check("wdata", WDATA_M, m_wdata);
                check("wstrb", WSTRB_M, m_wstrb);
            end
            check("bready",     BREADY_M,       m_busy && m_we && m_aw && m_w);

            // advance the model across the coming edge
            if (ARESET) begin
                m_busy = 0; m_rv = 0; m_err = 0; m_rdata = '0; m_stall = 0;
            end else begin
                n_rv = 1'b0;
                prog = 1'b0;
                if (m_busy) begin
                    if (!m_we) begin
                        if (!m_ar) begin
                            if (ARREADY_M) begin m_ar = 1; prog = 1; end
                        end else if (RVALID_M) begin
                            n_rv = 1; m_rdata = RDATA_M; m_err = (RRESP_M != 2'b00);
                            m_busy = 0; prog = 1;
                        end
                    end else begin
                        if (m_aw && m_w) begin
                            if (BVALID_M) begin
                                n_rv = 1; m_err = (BRESP_M != 2'b00); m_busy = 0; prog = 1;
                            end
                        end else begin
                            if (!m_aw && AWREADY_M) begin m_aw = 1; prog = 1; end
                            if (!m_w && WREADY_M)   begin m_w = 1;  prog = 1; end
                        end
                    end
`ifdef AXI_TIMEOUT_EN
                    if (prog) m_stall = 0;
                    else if (m_stall == TO - 1) begin
                        m_busy = 0; n_rv = 1; m_err = 1; m_stall = 0;
                    end else m_stall++;
`endif
                end else if (cpu_req_valid) begin
                    m_busy = 1; m_we = cpu_req_we; m_addr = cpu_req_addr;
                    m_wdata = cpu_req_wdata; m_wstrb = cpu_req_wstrb;
                    m_ar = 0; m_aw = 0; m_w = 0; m_stall = 0;
                end
                m_rv = n_rv;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output int acc);
        int n = 0;
        cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = addr;
        cpu_req_wdata = wdata; cpu_req_wstrb = wstrb;
        while (!cpu_req_ready && n < 50) begin tick(); n++; end
        check("req_ready_bound", cpu_req_ready, 1'b1);
        acc = cyc;
        tick();
        cpu_req_valid = 0;
    endtask

    // AR after ar_wait cycles, RVALID r_delay cycles after the AR handshake cycle.
    task automatic serve_read(input int ar_wait, input int r_delay,
                              input logic [31:0] data, input logic [1:0] resp);
        ARREADY_M = 0;
        repeat (ar_wait) tick();
        ARREADY_M = 1;
        tick();
        ARREADY_M = 0;
        repeat (r_delay - 1) tick();
        RVALID_M = 1; RDATA_M = data; RRESP_M = resp;
        tick();
        RVALID_M = 0;
    endtask

    task automatic serve_write(input int aw_wait, input int w_wait, input int b_delay,
                               input logic [1:0] resp);
        logic awd = 0, wd = 0;
        int k = 0;
        while (!(awd && wd) && k < 50) begin
            AWREADY_M = !awd && (k >= aw_wait);
            WREADY_M  = !wd  && (k >= w_wait);
            tick();
            if (AWREADY_M) awd = 1;
            if (WREADY_M)  wd  = 1;
            k++;
        end
        AWREADY_M = 0; WREADY_M = 0;
        repeat (b_delay) tick();
        BVALID_M = 1; BRESP_M = resp;
        tick();
        BVALID_M = 0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int acc, s_ar, s_aw, s_w, s_rr, s_br, n;
        ARESET = 1;
        cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0; cpu_req_wdata = '0; cpu_req_wstrb = '0;
        ARREADY_M = 0; RDATA_M = '0; RRESP_M = '0; RVALID_M = 0;
        AWREADY_M = 0; WREADY_M = 0; BRESP_M = '0; BVALID_M = 0;
        repeat (3) tick();
        ARESET = 0;
        check("rst_req_ready",  cpu_req_ready,  1'b1);
        check("rst_resp_valid", cpu_resp_valid, 1'b0);
        check("rst_rdata",      cpu_resp_rdata, 32'h0);
        check("rst_err",        cpu_resp_err,   1'b0);
        check("rst_arvalid",    ARVALID_M,      1'b0);
        tick();

        // zero-wait read: response pulse 4 cycles after accept
        s_ar = arv_cnt;
        issue_req(0, 32'h0000_0010, '0, '0, acc);
        serve_read(0, 2, 32'hDEAD_BEEF, 2'b00);
        $display("[TB] read  0x00000010 -> rdata=0x%08h err=%0b latency=%0d", cpu_resp_rdata, cpu_resp_err, cyc - acc);
        check("t1_latency", cyc - acc, 4);
        check("t1_valid",   cpu_resp_valid, 1'b1);
        check("t1_rdata",   cpu_resp_rdata, 32'hDEAD_BEEF);
        check("t1_err",     cpu_resp_err,   1'b0);
        check("t1_arv_cycles", arv_cnt - s_ar, 1);
        tick();
        check("t1_pulse_once", cpu_resp_valid, 1'b0);

        // write with AWREADY held off 3 cycles, WREADY immediate
        s_aw = awv_cnt; s_w = wv_cnt; s_br = br_cnt;
        issue_req(1, 32'h0000_0020, 32'h1234_5678, 4'b0011, acc);
        serve_write(3, 0, 1, 2'b00);
        $display("[TB] write 0x00000020 data=0x12345678 -> err=%0b", cpu_resp_err);
        check("t2_valid",       cpu_resp_valid, 1'b1);
        check("t2_err",         cpu_resp_err,   1'b0);
        check("t2_rdata_kept",  cpu_resp_rdata, 32'hDEAD_BEEF);
        check("t2_awv_cycles",  awv_cnt - s_aw, 4);
        check("t2_wv_cycles",   wv_cnt - s_w,   1);
        check("t2_br_cycles",   br_cnt - s_br,  2);
        tick();

        // SLVERR read then OKAY read
        issue_req(0, 32'h0000_0030, '0, '0, acc);
        serve_read(1, 1, 32'hCAFE_F00D, 2'b10);
        $display("[TB] read  0x00000030 -> rdata=0x%08h err=%0b", cpu_resp_rdata, cpu_resp_err);
        check("t3_err_slverr", cpu_resp_err,   1'b1);
        check("t3_rdata",      cpu_resp_rdata, 32'hCAFE_F00D);
        tick();
        issue_req(0, 32'h0000_0034, '0, '0, acc);
        serve_read(0, 2, 32'h0BAD_C0DE, 2'b00);
        $display("[TB] read  0x00000034 -> rdata=0x%08h err=%0b", cpu_resp_rdata, cpu_resp_err);
        check("t3_err_okay",   cpu_resp_err,   1'b0);
        check("t3_rdata2",     cpu_resp_rdata, 32'h0BAD_C0DE);
        tick();

        // back-to-back: write request held while a slow read completes
        s_ar = arv_cnt; s_rr = rr_cnt;
        issue_req(0, 32'h0000_0040, '0, '0, acc);
        cpu_req_valid = 1; cpu_req_we = 1; cpu_req_addr = 32'h0000_0044;
        cpu_req_wdata = 32'hA5A5_A5A5; cpu_req_wstrb = 4'b1111;
        serve_read(0, 5, 32'h1122_3344, 2'b00);
        $display("[TB] read  0x00000040 -> rdata=0x%08h err=%0b (write pending)", cpu_resp_rdata, cpu_resp_err);
        check("t4_pulse",      cpu_resp_valid, 1'b1);
        check("t4_ready_pulse", cpu_req_ready, 1'b1);
        check("t4_arv_cycles", arv_cnt - s_ar, 1);
        check("t4_rr_cycles",  rr_cnt - s_rr,  5);
        tick();
        cpu_req_valid = 0;
        check("t4_accepted",   cpu_req_ready,  1'b0);
        serve_write(0, 0, 0, 2'b00);
        $display("[TB] write 0x00000044 data=0xa5a5a5a5 -> err=%0b", cpu_resp_err);
        check("t4_wr_valid",   cpu_resp_valid, 1'b1);
        tick();

        // stray RVALID/BVALID while idle must not be acknowledged
        RVALID_M = 1; BVALID_M = 1; RRESP_M = 2'b10; BRESP_M = 2'b10;
        repeat (3) tick();
        $display("[TB] stray R/B in idle -> rready=%0b bready=%0b", RREADY_M, BREADY_M);
        check("t5_no_resp",  cpu_resp_valid, 1'b0);
        check("t5_rready",   RREADY_M,       1'b0);
        RVALID_M = 0; BVALID_M = 0; RRESP_M = 2'b00; BRESP_M = 2'b00;
        tick();

        // reset while waiting for B
        issue_req(1, 32'h0000_0050, 32'h0F0F_0F0F, 4'b1000, acc);
        AWREADY_M = 1; WREADY_M = 1;
        tick();
        AWREADY_M = 0; WREADY_M = 0;
        tick();
        check("t6_bready_before", BREADY_M, 1'b1);
        ARESET = 1;
        tick();
        ARESET = 0;
        $display("[TB] reset in WR_RESP -> req_ready=%0b bready=%0b resp_valid=%0b", cpu_req_ready, BREADY_M, cpu_resp_valid);
        check("t6_bready",     BREADY_M,       1'b0);
        check("t6_awvalid",    AWVALID_M,      1'b0);
        check("t6_wvalid",     WVALID_M,       1'b0);
        check("t6_req_ready",  cpu_req_ready,  1'b1);
        check("t6_no_resp",    cpu_resp_valid, 1'b0);
        check("t6_rdata_rst",  cpu_resp_rdata, 32'h0);
        tick();
        check("t6_no_resp2",   cpu_resp_valid, 1'b0);

        // ordinary read after reset
        issue_req(0, 32'h0000_0060, '0, '0, acc);
        serve_read(0, 2, 32'h5A5A_5A5A, 2'b00);
        $display("[TB] read  0x00000060 -> rdata=0x%08h err=%0b", cpu_resp_rdata, cpu_resp_err);
        check("t7_rdata", cpu_resp_rdata, 32'h5A5A_5A5A);
        check("t7_latency", cyc - acc, 4);
        tick();

`ifdef AXI_TIMEOUT_EN
        // ARREADY stuck low: watchdog aborts 8 cycles after entering RD_ADDR
        s_ar = arv_cnt;
        issue_req(0, 32'h0000_0070, '0, '0, acc);
        ARREADY_M = 0;
        n = 0;
        while (!cpu_resp_valid && n < 30) begin tick(); n++; end
        $display("[TB] read  0x00000070 timeout -> err=%0b latency=%0d", cpu_resp_err, cyc - acc);
        check("t8_valid",      cpu_resp_valid, 1'b1);
        check("t8_latency",    cyc - acc,      9);
        check("t8_err",        cpu_resp_err,   1'b1);
        check("t8_rdata_kept", cpu_resp_rdata, 32'h5A5A_5A5A);
        check("t8_arv_cycles", arv_cnt - s_ar, TO);
        tick();
        check("t8_resp_count", resp_cnt, 8);
`else
        n = 0;
        check("t8_resp_count", resp_cnt, 7 + n);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
